// File: rtl/pipelined_mips_cpu.sv
// Five-stage in-order MIPS-subset core (IF/ID/EX/MEM/WB) with forwarding, load-use stall and ID-stage branch/jump.
// Latency: one instruction per cycle; results written back four cycles after fetch; taken beq/j cost one bubble.
// Backpressure: start_i=0 holds PC and feeds NOPs while the pipe drains; CPU_PERF_CNT_EN adds stall/flush counters.
module pipelined_mips_cpu #(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_BYTES = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic [31:0] pc_o,
    output logic        stall_o,
    output logic        flush_o
`ifdef CPU_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
`endif
);
    localparam int IA_W = $clog2(IMEM_WORDS);
    localparam int DA_W = $clog2(DMEM_BYTES);

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_MUL} alu_op_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        alu_src;
        alu_op_t     alu_op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
    } idex_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        mem_to_reg;
        logic [4:0]  dst;
        logic [31:0] alu;
        logic [31:0] sdat;
    } exmem_t;

    typedef struct packed {
        logic        reg_write;
        logic [4:0]  dst;
        logic [31:0] res;
    } memwb_t;

    logic [31:0] imem [0:IMEM_WORDS-1];
    logic [31:0] regs [0:31];
    logic [7:0]  dmem [0:DMEM_BYTES-1];

    logic [31:0] pc, ifid_instr, ifid_pc;
    idex_t       idex;
    exmem_t      exmem;
    memwb_t      memwb;

    // ID-stage fields
    logic [5:0]  id_op, id_funct;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_imm, id_a, id_b, pcp4_id, redirect_pc;
    idex_t       id_ctl;
    logic        is_beq, is_j, load_use, flush, stall;

    assign id_op    = ifid_instr[31:26];
    assign id_rs    = ifid_instr[25:21];
    assign id_rt    = ifid_instr[20:16];
    assign id_rd    = ifid_instr[15:11];
    assign id_funct = ifid_instr[5:0];
    assign id_imm   = {{16{ifid_instr[15]}}, ifid_instr[15:0]};
    assign pcp4_id  = ifid_pc + 32'd4;

    // Register read with same-cycle write-back bypass; r0 is hardwired to zero
    always_comb begin
        id_a = regs[id_rs];
        id_b = regs[id_rt];
        if (memwb.reg_write && memwb.dst == id_rs) id_a = memwb.res;
        if (memwb.reg_write && memwb.dst == id_rt) id_b = memwb.res;
        if (id_rs == 5'd0) id_a = 32'd0;
        if (id_rt == 5'd0) id_b = 32'd0;
    end

    // Decode into the ID/EX control bundle; unknown opcodes/functs leave every control bit low
    always_comb begin
        id_ctl = '0;
        id_ctl.alu_op = ALU_ADD;
        id_ctl.rs  = id_rs;
        id_ctl.rt  = id_rt;
        id_ctl.dst = id_rd;
        id_ctl.a   = id_a;
        id_ctl.b   = id_b;
        id_ctl.imm = id_imm;
        is_beq = 1'b0;
        is_j   = 1'b0;
        case (id_op)
            6'b000000: begin
                case (id_funct)
                    6'b100000: begin id_ctl.reg_write = 1'b1; id_ctl.alu_op = ALU_ADD; end
                    6'b100010: begin id_ctl.reg_write = 1'b1; id_ctl.alu_op = ALU_SUB; end
                    6'b100100: begin id_ctl.reg_write = 1'b1; id_ctl.alu_op = ALU_AND; end
                    6'b100101: begin id_ctl.reg_write = 1'b1; id_ctl.alu_op = ALU_OR;  end
                    6'b011000: begin id_ctl.reg_write = 1'b1; id_ctl.alu_op = ALU_MUL; end
                    default: ;
                endcase
            end
            6'b001000: begin
                id_ctl.reg_write = 1'b1;
                id_ctl.alu_src   = 1'b1;
                id_ctl.dst       = id_rt;
            end
            6'b100011: begin
                id_ctl.reg_write  = 1'b1;
                id_ctl.mem_read   = 1'b1;
                id_ctl.mem_to_reg = 1'b1;
                id_ctl.alu_src    = 1'b1;
                id_ctl.dst        = id_rt;
            end
            6'b101011: begin
                id_ctl.mem_write = 1'b1;
                id_ctl.alu_src   = 1'b1;
            end
            6'b000100: is_beq = 1'b1;
            6'b000010: is_j   = 1'b1;
            default: ;
        endcase
    end

    // Hazard decision: a redirect discards the younger instruction, so it overrides a load-use stall
    always_comb begin
        load_use    = idex.mem_read && (idex.rt == id_rs || idex.rt == id_rt);
        flush       = is_j || (is_beq && id_a == id_b);
        stall       = load_use && !flush;
        redirect_pc = is_j ? {pcp4_id[31:28], ifid_instr[25:0], 2'b00}
                           : pcp4_id + {id_imm[29:0], 2'b00};
    end

    // PC and IF/ID: redirect, hold on stall, advance when running, otherwise feed NOPs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc         <= 32'd0;
            ifid_instr <= 32'd0;
            ifid_pc    <= 32'd0;
        end else if (flush) begin
            pc         <= redirect_pc;
            ifid_instr <= 32'd0;
            ifid_pc    <= 32'd0;
        end else if (stall) begin
            pc         <= pc;
        end else if (start_i) begin
            pc         <= pc + 32'd4;
            ifid_instr <= imem[pc[IA_W+1:2]];
            ifid_pc    <= pc;
        end else begin
            ifid_instr <= 32'd0;
            ifid_pc    <= 32'd0;
        end
    end

    // ID/EX: a stall inserts a bubble behind the load
    always_ff @(posedge clk_i) begin
        if (rst_i || stall) idex <= '0;
        else                idex <= id_ctl;
    end

    // EX operand forwarding: EX/MEM beats MEM/WB beats the value read in ID
    logic [31:0] fwd_a, fwd_b, op_b, alu_res;
    always_comb begin
        fwd_a = idex.a;
        fwd_b = idex.b;
        if (memwb.reg_write && memwb.dst != 5'd0 && memwb.dst == idex.rs) fwd_a = memwb.res;
        if (memwb.reg_write && memwb.dst != 5'd0 && memwb.dst == idex.rt) fwd_b = memwb.res;
        if (exmem.reg_write && exmem.dst != 5'd0 && exmem.dst == idex.rs) fwd_a = exmem.alu;
        if (exmem.reg_write && exmem.dst != 5'd0 && exmem.dst == idex.rt) fwd_b = exmem.alu;
        op_b = idex.alu_src ? idex.imm : fwd_b;
    end

    // ALU; mul keeps the low word of the product
    always_comb begin
        alu_res = fwd_a + op_b;
        case (idex.alu_op)
            ALU_SUB: alu_res = fwd_a - op_b;
            ALU_AND: alu_res = fwd_a & op_b;
            ALU_OR:  alu_res = fwd_a | op_b;
            ALU_MUL: alu_res = fwd_a * op_b;
            default: alu_res = fwd_a + op_b;
        endcase
    end

    // EX/MEM register
    always_ff @(posedge clk_i) begin
        if (rst_i) exmem <= '0;
        else       exmem <= '{reg_write: idex.reg_write, mem_write: idex.mem_write,
                              mem_to_reg: idex.mem_to_reg, dst: idex.dst,
                              alu: alu_res, sdat: fwd_b};
    end

    // Little-endian word access; byte addresses wrap inside the data memory
    logic [DA_W-1:0] ma0, ma1, ma2, ma3;
    logic [31:0]     ld_dat;
    assign ma0    = exmem.alu[DA_W-1:0];
    assign ma1    = ma0 + DA_W'(1);
    assign ma2    = ma0 + DA_W'(2);
    assign ma3    = ma0 + DA_W'(3);
    assign ld_dat = {dmem[ma3], dmem[ma2], dmem[ma1], dmem[ma0]};

    // Data memory store
    always_ff @(posedge clk_i) begin
        if (exmem.mem_write) begin
            dmem[ma0] <= exmem.sdat[7:0];
            dmem[ma1] <= exmem.sdat[15:8];
            dmem[ma2] <= exmem.sdat[23:16];
            dmem[ma3] <= exmem.sdat[31:24];
        end
    end

    // MEM/WB register
    always_ff @(posedge clk_i) begin
        if (rst_i) memwb <= '0;
        else       memwb <= '{reg_write: exmem.reg_write, dst: exmem.dst,
                              res: exmem.mem_to_reg ? ld_dat : exmem.alu};
    end

    // Register file write-back; writes to r0 are dropped
    always_ff @(posedge clk_i) begin
        if (memwb.reg_write && memwb.dst != 5'd0) regs[memwb.dst] <= memwb.res;
    end

`ifdef CPU_PERF_CNT_EN
    // Saturating stall/flush event counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_o <= 32'd0;
            flush_cnt_o <= 32'd0;
        end else begin
            if (stall_o && stall_cnt_o != 32'hFFFF_FFFF) stall_cnt_o <= stall_cnt_o + 32'd1;
            if (flush_o && flush_cnt_o != 32'hFFFF_FFFF) flush_cnt_o <= flush_cnt_o + 32'd1;
        end
    end
`endif

    assign pc_o    = pc;
    assign stall_o = stall;
    assign flush_o = flush;
endmodule

// File: tb/tb_pipelined_mips_cpu.sv
// Bench for pipelined_mips_cpu: vector table of single instructions plus hand-built multi-cycle programs.
// Expected register/memory/PC values are queued on the scoreboard when a program is loaded, then drained.
// Builds with or without CPU_PERF_CNT_EN.
module tb_pipelined_mips_cpu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] pc_o;
    logic        stall_o, flush_o;
`ifdef CPU_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    pipelined_mips_cpu dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .pc_o    (pc_o),
        .stall_o (stall_o),
        .flush_o (flush_o)
`ifdef CPU_PERF_CNT_EN
        ,
        .stall_cnt_o (stall_cnt),
        .flush_cnt_o (flush_cnt)
`endif
    );

    int n_chk = 0;
    int n_err = 0;
    int stall_seen = 0;
    int flush_seen = 0;

    // Count hazard events mid-cycle while out of reset
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (stall_o) stall_seen++;
            if (flush_o) flush_seen++;
        end
    end

    localparam logic [5:0] ADDI = 6'b001000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
    localparam logic [5:0] F_OR = 6'b100101, F_MUL = 6'b011000;

    function automatic logic [31:0] r_t(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] f);
        return {6'b000000, rs, rt, rd, 5'b00000, f};
    endfunction
    function automatic logic [31:0] i_t(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction
    function automatic logic [31:0] j_t(input logic [25:0] tgt);
        return {6'b000010, tgt};
    endfunction

    typedef struct {
        string       name;
        int          kind;   // 0 register, 1 data-memory byte, 2 pc_o
        int          idx;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        int          dreg;
        logic [31:0] exp;
    } vec_t;
    vec_t vt[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push(input string name, input int kind, input int idx, input logic [31:0] val);
        exp_t e;
        e.name = name; e.kind = kind; e.idx = idx; e.val = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] act;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                0:       act = dut.regs[e.idx];
                1:       act = {24'd0, dut.dmem[e.idx]};
                default: act = pc_o;
            endcase
            check(e.name, act, e.val);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold reset two edges, then clear memories and registers while the pipe is empty
    task automatic begin_test();
        rst = 1'b1;
        start = 1'b0;
        step(2);
        for (int i = 0; i < 256; i++) dut.imem[i] = 32'd0;
        for (int i = 0; i < 32; i++) dut.dmem[i] = 8'd0;
        for (int i = 0; i < 32; i++) dut.regs[i] = 32'd0;
    endtask

    task automatic go();
        rst = 1'b0;
        start = 1'b1;
    endtask

    initial begin
        int s0, f0, k;

        vt[0] = '{"add",      r_t(1, 2, 3, F_ADD), 32'd5,         32'd7,         3, 32'd12};
        vt[1] = '{"sub_neg",  r_t(1, 2, 3, F_SUB), 32'd5,         32'd7,         3, 32'hFFFF_FFFE};
        vt[2] = '{"and",      r_t(1, 2, 3, F_AND), 32'hF0F0_1234, 32'h0FF0_FF00, 3, 32'h00F0_1200};
        vt[3] = '{"or",       r_t(1, 2, 3, F_OR),  32'hF000_0000, 32'h0000_000F, 3, 32'hF000_000F};
        vt[4] = '{"mul_low",  r_t(1, 2, 3, F_MUL), 32'h0001_0003, 32'h0001_0002, 3, 32'h0005_0006};
        vt[5] = '{"mul_neg",  r_t(1, 2, 3, F_MUL), 32'hFFFF_FFFF, 32'd3,         3, 32'hFFFF_FFFD};
        vt[6] = '{"addi_neg", i_t(ADDI, 1, 3, 16'hFFFF), 32'd10,  32'd0,         3, 32'd9};
        vt[7] = '{"bad_op",   i_t(6'b001111, 1, 3, 16'h1234), 32'd1, 32'd2,      3, 32'h0BAD_F00D};
        vt[8] = '{"r0_write", r_t(1, 2, 0, F_ADD), 32'd5,         32'd7,         0, 32'd0};
        vt[9] = '{"bad_funct", r_t(1, 2, 3, 6'b000000), 32'd5,    32'd7,         3, 32'h0BAD_F00D};

        // Reset state, PC sequence, start_i=0 hold
        begin_test();
        go();
        check("rst_pc", pc_o, 32'd0);
        check("rst_stall", {31'd0, stall_o}, 32'd0);
        check("rst_flush", {31'd0, flush_o}, 32'd0);
        for (int i = 1; i <= 3; i++) begin
            push($sformatf("pc_seq%0d", i), 2, 0, 32'(4 * i));
            step(1);
            drain();
        end
        start = 1'b0;
        push("pc_hold_a", 2, 0, 32'd12);
        step(1);
        drain();
        push("pc_hold_b", 2, 0, 32'd12);
        step(1);
        drain();

        // Single-instruction vector table
        for (int v = 0; v < 10; v++) begin
            begin_test();
            dut.imem[0] = vt[v].instr;
            dut.regs[1] = vt[v].a;
            dut.regs[2] = vt[v].b;
            dut.regs[3] = 32'h0BAD_F00D;
            push(vt[v].name, 0, vt[v].dreg, vt[v].exp);
            go();
            step(8);
            drain();
        end

        // ALU chain exercising both forwarding paths, their priority, and the ID write-back bypass
        begin_test();
        dut.imem[0]  = i_t(ADDI, 0, 8, 16'd5);
        dut.imem[1]  = i_t(ADDI, 8, 9, 16'd3);
        dut.imem[2]  = r_t(9, 8, 10, F_SUB);
        dut.imem[3]  = r_t(9, 10, 11, F_MUL);
        dut.imem[4]  = i_t(ADDI, 0, 13, 16'd1);
        dut.imem[5]  = i_t(ADDI, 0, 13, 16'd2);
        dut.imem[6]  = r_t(13, 13, 12, F_ADD);
        dut.imem[7]  = i_t(ADDI, 0, 14, 16'd7);
        dut.imem[10] = r_t(14, 14, 15, F_ADD);
        push("fwd_r8", 0, 8, 32'd5);
        push("fwd_r9", 0, 9, 32'd8);
        push("fwd_r10", 0, 10, 32'd3);
        push("fwd_r11", 0, 11, 32'd24);
        push("fwd_prio_r12", 0, 12, 32'd4);
        push("fwd_r13", 0, 13, 32'd2);
        push("wb_bypass_r15", 0, 15, 32'd14);
        s0 = stall_seen;
        go();
        step(20);
        drain();
        check("fwd_no_stall", 32'(stall_seen - s0), 32'd0);

        // Load-use stall, store with forwarded data, wrapped load address
        begin_test();
        dut.dmem[0]  = 8'h05;
        dut.dmem[30] = 8'hAA;
        dut.dmem[31] = 8'hBB;
        dut.imem[0] = i_t(LW, 0, 8, 16'd0);
        dut.imem[1] = r_t(8, 8, 9, F_ADD);
        dut.imem[2] = i_t(SW, 0, 9, 16'd4);
        dut.imem[3] = i_t(LW, 0, 16, 16'd30);
        push("lw_r8", 0, 8, 32'd5);
        push("loaduse_r9", 0, 9, 32'd10);
        push("sw_b4", 1, 4, 32'h0A);
        push("sw_b5", 1, 5, 32'h00);
        push("sw_b6", 1, 6, 32'h00);
        push("sw_b7", 1, 7, 32'h00);
        push("lw_wrap_r16", 0, 16, 32'h0005_BBAA);
        s0 = stall_seen;
        go();
        step(16);
        drain();
        check("loaduse_stalls", 32'(stall_seen - s0), 32'd1);

        // Untaken beq falls through; taken beq skips two and flushes once
        begin_test();
        dut.imem[0] = i_t(ADDI, 0, 20, 16'd1);
        dut.imem[3] = i_t(BEQ, 20, 0, 16'd5);
        dut.imem[4] = i_t(BEQ, 0, 0, 16'd2);
        dut.imem[5] = i_t(ADDI, 0, 21, 16'd9);
        dut.imem[6] = i_t(ADDI, 0, 22, 16'd9);
        dut.imem[7] = i_t(ADDI, 0, 23, 16'd7);
        push("beq_r20", 0, 20, 32'd1);
        push("beq_skip_r21", 0, 21, 32'd0);
        push("beq_skip_r22", 0, 22, 32'd0);
        push("beq_target_r23", 0, 23, 32'd7);
        f0 = flush_seen;
        go();
        step(20);
        drain();
        check("beq_flushes", 32'(flush_seen - f0), 32'd1);

        // Jump-to-self loop: PC alternates 8 (fetch j) and 12 (j in ID, flush)
        begin_test();
        dut.imem[2] = j_t(26'd2);
        go();
        k = 0;
        while (pc_o !== 32'd8 && k < 12) begin
            step(1);
            k++;
        end
        check("jloop_reach", pc_o, 32'd8);
        for (int it = 0; it < 4; it++) begin
            check($sformatf("jloop_pc_a%0d", it), pc_o, 32'd8);
            check($sformatf("jloop_noflush%0d", it), {31'd0, flush_o}, 32'd0);
`ifdef CPU_PERF_CNT_EN
            check($sformatf("jloop_fcnt%0d", it), flush_cnt, 32'(it));
            check($sformatf("jloop_scnt%0d", it), stall_cnt, 32'd0);
`endif
            step(1);
            check($sformatf("jloop_pc_b%0d", it), pc_o, 32'd12);
            check($sformatf("jloop_flush%0d", it), {31'd0, flush_o}, 32'd1);
            step(1);
        end

        // Jump in ID over a load whose rt matches: flush wins, no stall; target wraps IMEM
        begin_test();
        dut.imem[0] = i_t(LW, 0, 2, 16'd0);
        dut.imem[1] = j_t(26'h20000);
        s0 = stall_seen;
        f0 = flush_seen;
        go();
        k = 0;
        while (pc_o !== 32'h0008_0000 && k < 12) begin
            step(1);
            k++;
        end
        check("jwrap_reach", pc_o, 32'h0008_0000);
        step(10);
        check("flush_over_stall", 32'(stall_seen - s0), 32'd0);
        check("jwrap_flushed", {31'd0, (flush_seen - f0) > 0}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
